// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: write-only HD44780 bus timing engine.
// One byte per accepted ctrl_Start rising edge: RS/DATA setup, an LCD_EN
// high pulse, then hold, then a one-cycle ctrl_Done pulse.
// Optional feature macro: LCD_LONG_WAIT_EN -- adds a LONG_WAIT state after
// clear-display (8'h01) and return-home (8'h02) commands. When the macro is
// undefined the state and its logic are not built.
`timescale 1ns/1ps

module lcd_bus_driver #(
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned EN_HIGH_CYC   = 25,
  parameter int unsigned HOLD_CYC      = 4,
  parameter int unsigned LONG_WAIT_CYC = 82000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       ctrl_RS,
  input  logic       ctrl_Start,
  input  logic [7:0] ctrl_DATA,
  output logic       ctrl_Done,
  output logic       ctrl_Busy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  // A zero-length phase still takes one cycle.
  localparam int unsigned SETUP_N = (SETUP_CYC     == 0) ? 1 : SETUP_CYC;
  localparam int unsigned EN_N    = (EN_HIGH_CYC   == 0) ? 1 : EN_HIGH_CYC;
  localparam int unsigned HOLD_N  = (HOLD_CYC      == 0) ? 1 : HOLD_CYC;
  localparam int unsigned LW_N    = (LONG_WAIT_CYC == 0) ? 1 : LONG_WAIT_CYC;

  // Counter wide enough for the longest phase, never narrower than 17 bits.
  localparam int unsigned MAX_A = (SETUP_N > EN_N) ? SETUP_N : EN_N;
  localparam int unsigned MAX_B = (HOLD_N > LW_N) ? HOLD_N : LW_N;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W = ($clog2(MAX_C + 1) > 17) ? $clog2(MAX_C + 1) : 17;

  // Counter load values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_N - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_N - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_N - 1);
`ifdef LCD_LONG_WAIT_EN
  localparam logic [CNT_W-1:0] LW_LD    = CNT_W'(LW_N - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_EN_HI     = 3'd2,
    S_HOLD      = 3'd3,
`ifdef LCD_LONG_WAIT_EN
    S_LONG_WAIT = 3'd4,
`endif
    S_DONE      = 3'd5
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             start_prev_q;
  logic             rs_q;
  logic [7:0]       data_q;
  logic             en_q;
  logic             done_q;
  logic             busy_q;
  logic             start_edge;

  // Rising edge of ctrl_Start; start_prev_q tracks the input in every state,
  // so a level still high on return to IDLE is not a new request.
  assign start_edge = ctrl_Start && !start_prev_q;

`ifdef LCD_LONG_WAIT_EN
  // Clear-display and return-home need the long post-command wait.
  logic long_cmd;
  assign long_cmd = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));
`endif

  // Transfer sequencer. All outputs are registered and updated together with
  // the state they belong to, so LCD_EN is high exactly while in EN_HI.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      start_prev_q <= 1'b0;
      rs_q         <= 1'b0;
      data_q       <= 8'h00;
      en_q         <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking would make ordering within the block matter.
      start_prev_q <= ctrl_Start;
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_q <= S_SETUP;
            cnt_q   <= SETUP_LD;
            rs_q    <= ctrl_RS;
            data_q  <= ctrl_DATA;
            busy_q  <= 1'b1;
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= S_EN_HI;
            cnt_q   <= EN_LD;
            en_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_EN_HI: begin
          if (cnt_q == '0) begin
            state_q <= S_HOLD;
            cnt_q   <= HOLD_LD;
            en_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
`ifdef LCD_LONG_WAIT_EN
            if (long_cmd) begin
              state_q <= S_LONG_WAIT;
              cnt_q   <= LW_LD;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
`else
            state_q <= S_DONE;
            done_q  <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`ifdef LCD_LONG_WAIT_EN
        S_LONG_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          en_q    <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign LCD_DATA  = data_q;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_EN    = en_q;
  assign ctrl_Done = done_q;
  assign ctrl_Busy = busy_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Self-checking bench for lcd_bus_driver: table-driven single transfers plus
// hand-written sequences (ignored edge, reset mid-pulse, start held through
// reset, back-to-back). Expected transfers are queued when driven and
// checked when ctrl_Done appears.
`timescale 1ns/1ps

module tb_lcd_bus_driver;

  localparam int CLK_P     = 10;
  localparam int SETUP_C   = 4;
  localparam int EN_C      = 25;
  localparam int HOLD_C    = 4;
  localparam int LW_C      = 82000;
  localparam int NOM_LAT   = SETUP_C + EN_C + HOLD_C + 1;

  logic       iCLK;
  logic       iRST_N;
  logic       ctrl_RS;
  logic       ctrl_Start;
  logic [7:0] ctrl_DATA;
  logic       ctrl_Done;
  logic       ctrl_Busy;
  logic [7:0] LCD_DATA;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;

  lcd_bus_driver #(
    .SETUP_CYC    (SETUP_C),
    .EN_HIGH_CYC  (EN_C),
    .HOLD_CYC     (HOLD_C),
    .LONG_WAIT_CYC(LW_C)
  ) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .ctrl_RS   (ctrl_RS),
    .ctrl_Start(ctrl_Start),
    .ctrl_DATA (ctrl_DATA),
    .ctrl_Done (ctrl_Done),
    .ctrl_Busy (ctrl_Busy),
    .LCD_DATA  (LCD_DATA),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .LCD_EN    (LCD_EN)
  );

  initial iCLK = 1'b0;
  always #(CLK_P / 2) iCLK = ~iCLK;

  typedef struct {
    time        t_drive;
    logic       rs;
    logic [7:0] data;
    int         lat;
  } exp_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         hold;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   en_pulses = 0;
  int   done_cnt  = 0;
  int   en_len    = 0;
  time  en_rise_t = 0;
  logic en_prev   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic rs, input logic [7:0] d);
`ifdef LCD_LONG_WAIT_EN
    if (!rs && (d == 8'h01 || d == 8'h02)) return NOM_LAT + LW_C;
`endif
    return NOM_LAT;
  endfunction

  // Drive one start edge (caller is at a negedge) and queue the expectation.
  task automatic drive_req(input logic rs, input logic [7:0] d, input logic expect_it);
    exp_t e;
    ctrl_RS    = rs;
    ctrl_DATA  = d;
    ctrl_Start = 1'b1;
    if (expect_it) begin
      e.t_drive = $time;
      e.rs      = rs;
      e.data    = d;
      e.lat     = exp_lat(rs, d);
      sb.push_back(e);
    end
  endtask

  // Wait for all queued transfers to complete, within a cycle budget.
  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while ((sb.size() != 0 || ctrl_Busy) && i < budget) begin
      @(negedge iCLK);
      i++;
    end
    if (i >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle_timeout: pending %0d busy %0b after %0d cycles", sb.size(), ctrl_Busy, budget);
      sb.delete();
    end
  endtask

  // Monitor: tracks LCD_EN pulses and scores each ctrl_Done against the queue.
  always @(negedge iCLK) begin
    if (!iRST_N) begin
      en_prev = 1'b0;
    end else begin
      if (LCD_EN && !en_prev) begin
        en_rise_t = $time;
        en_len    = 0;
        en_pulses++;
      end
      if (LCD_EN) en_len++;
      en_prev = LCD_EN;
      if (ctrl_Done) begin
        exp_t e;
        done_cnt++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: ctrl_Done with nothing pending at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("done_latency", 32'((($time - e.t_drive) / CLK_P)), 32'(e.lat));
          check("en_offset", 32'(((en_rise_t - e.t_drive) / CLK_P)), 32'(SETUP_C + 1));
          check("en_width", 32'(en_len), 32'(EN_C));
          check("lcd_data", 32'(LCD_DATA), 32'(e.data));
          check("lcd_rs", 32'(LCD_RS), 32'(e.rs));
          check("lcd_rw", 32'(LCD_RW), 32'd0);
          check("busy_at_done", 32'(ctrl_Busy), 32'd1);
        end
      end
    end
  end

  // One-cycle-wide ctrl_Done: it must never be high on two consecutive samples.
  logic done_prev = 1'b0;
  always @(negedge iCLK) begin
    if (ctrl_Done && done_prev) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_width: ctrl_Done high two cycles at %0t", $time);
    end
    done_prev = ctrl_Done;
  end

  vec_t vecs[6];
  logic [7:0] seq[4];
  int   budget;
  int   en0;
  int   dn0;

  initial begin
    budget = 200;
`ifdef LCD_LONG_WAIT_EN
    budget = LW_C + 400;
`endif
    vecs[0] = '{rs: 1'b0, data: 8'h38, hold: 1};
    vecs[1] = '{rs: 1'b1, data: 8'h41, hold: 100};
    vecs[2] = '{rs: 1'b0, data: 8'h0C, hold: 1};
    vecs[3] = '{rs: 1'b1, data: 8'h01, hold: 1};
    vecs[4] = '{rs: 1'b1, data: 8'hFF, hold: 3};
    vecs[5] = '{rs: 1'b0, data: 8'h00, hold: 2};
    seq[0] = 8'h38; seq[1] = 8'h0C; seq[2] = 8'h01; seq[3] = 8'h06;

    // Reset state.
    iRST_N = 1'b0; ctrl_RS = 1'b0; ctrl_Start = 1'b0; ctrl_DATA = 8'h00;
    repeat (3) @(negedge iCLK);
    check("rst_en", 32'(LCD_EN), 32'd0);
    check("rst_data", 32'(LCD_DATA), 32'h00);
    check("rst_rs", 32'(LCD_RS), 32'd0);
    check("rst_rw", 32'(LCD_RW), 32'd0);
    check("rst_done", 32'(ctrl_Done), 32'd0);
    check("rst_busy", 32'(ctrl_Busy), 32'd0);
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);

    // Table-driven single transfers.
    for (int v = 0; v < 6; v++) begin
      en0 = en_pulses; dn0 = done_cnt;
      drive_req(vecs[v].rs, vecs[v].data, 1'b1);
      repeat (vecs[v].hold) @(negedge iCLK);
      ctrl_Start = 1'b0;
      wait_idle(budget);
      repeat (3) @(negedge iCLK);
      check("vec_en_pulses", 32'(en_pulses - en0), 32'd1);
      check("vec_done_pulses", 32'(done_cnt - dn0), 32'd1);
      check("vec_data_kept", 32'(LCD_DATA), 32'(vecs[v].data));
    end

    // Second edge 10 cycles into a transfer is ignored, not queued.
    en0 = en_pulses; dn0 = done_cnt;
    drive_req(1'b1, 8'h41, 1'b1);
    @(negedge iCLK); ctrl_Start = 1'b0;
    repeat (9) @(negedge iCLK);
    drive_req(1'b0, 8'h55, 1'b0);
    @(negedge iCLK); ctrl_Start = 1'b0;
    wait_idle(budget);
    repeat (50) @(negedge iCLK);
    check("ign_data", 32'(LCD_DATA), 32'h41);
    check("ign_en_pulses", 32'(en_pulses - en0), 32'd1);
    check("ign_done_pulses", 32'(done_cnt - dn0), 32'd1);

    // Reset in the middle of EN_HI: everything drops immediately, no done.
    dn0 = done_cnt;
    drive_req(1'b1, 8'hA5, 1'b0);
    @(negedge iCLK); ctrl_Start = 1'b0;
    begin
      int i;
      i = 0;
      while (!LCD_EN && i < 50) begin @(negedge iCLK); i++; end
      check("mid_en_reached", 32'(LCD_EN), 32'd1);
    end
    repeat (5) @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    check("mid_rst_en", 32'(LCD_EN), 32'd0);
    check("mid_rst_data", 32'(LCD_DATA), 32'h00);
    check("mid_rst_rs", 32'(LCD_RS), 32'd0);
    check("mid_rst_busy", 32'(ctrl_Busy), 32'd0);
    check("mid_rst_done", 32'(ctrl_Done), 32'd0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    repeat (60) @(negedge iCLK);
    check("mid_rst_no_done", 32'(done_cnt - dn0), 32'd0);
    check("mid_rst_idle", 32'(ctrl_Busy), 32'd0);

    // Start held high through reset is taken as an edge on the first clock.
    @(negedge iCLK);
    iRST_N = 1'b0;
    ctrl_RS = 1'b1; ctrl_DATA = 8'h7E; ctrl_Start = 1'b1;
    repeat (2) @(negedge iCLK);
    en0 = en_pulses; dn0 = done_cnt;
    drive_req(1'b1, 8'h7E, 1'b1);
    iRST_N = 1'b1;
    repeat (5) @(negedge iCLK);
    ctrl_Start = 1'b0;
    wait_idle(budget);
    check("rel_en_pulses", 32'(en_pulses - en0), 32'd1);
    check("rel_done_pulses", 32'(done_cnt - dn0), 32'd1);

    // Back-to-back: re-raise start one cycle after each ctrl_Done.
    repeat (3) @(negedge iCLK);
    en0 = en_pulses; dn0 = done_cnt;
    for (int k = 0; k < 4; k++) begin
      int i;
      drive_req(1'b0, seq[k], 1'b1);
      @(negedge iCLK); ctrl_Start = 1'b0;
      i = 0;
      while (!ctrl_Done && i < budget) begin @(negedge iCLK); i++; end
      check("b2b_done_seen", 32'(ctrl_Done), 32'd1);
      @(negedge iCLK);
    end
    wait_idle(budget);
    check("b2b_en_pulses", 32'(en_pulses - en0), 32'd4);
    check("b2b_done_pulses", 32'(done_cnt - dn0), 32'd4);
    check("b2b_last_data", 32'(LCD_DATA), 32'h06);
    check("b2b_queue_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_bus_driver.md
LCD_BUS_DRIVER -- requirements
Module: lcd_bus_driver

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 4, meaning iCLK cycles of RS/DATA setup before LCD_EN rises.
REQ-002 SHALL have parameter EN_HIGH_CYC, default 25, meaning iCLK cycles LCD_EN is held high.
REQ-003 SHALL have parameter HOLD_CYC, default 4, meaning iCLK cycles RS/DATA are held after LCD_EN falls.
REQ-004 SHALL have parameter LONG_WAIT_CYC, default 82000, meaning extra wait cycles after clear/home (1.64 ms at 50 MHz).
REQ-005 SHALL have port iCLK, input, 1, system clock (50 MHz).
REQ-006 SHALL have port iRST_N, input, 1; reset iRST_N, asynchronous, active-low; clock iCLK.
REQ-007 SHALL have port ctrl_RS, input, 1, register select for the requested transfer (0 = command, 1 = data).
REQ-008 SHALL have port ctrl_Start, input, 1, transfer request.
REQ-009 SHALL have port ctrl_DATA, input, 8, byte to write.
REQ-010 SHALL have port ctrl_Done, output, 1, one-cycle pulse marking transfer completion.
REQ-011 SHALL have port ctrl_Busy, output, 1, high from acceptance through the ctrl_Done cycle.
REQ-012 SHALL have port LCD_DATA, output, 8, HD44780 data bus.
REQ-013 SHALL have ports LCD_RS, LCD_RW, LCD_EN, output, 1 each, HD44780 control lines.

Function
REQ-014 SHALL implement states IDLE, SETUP, EN_HI, HOLD, LONG_WAIT, DONE.
REQ-015 SHALL accept a request only in IDLE, on a ctrl_Start rising edge (current 1, previous-cycle sample 0).
REQ-016 SHALL latch ctrl_RS and ctrl_DATA on the acceptance edge and drive them on LCD_RS and LCD_DATA, registered, from the next cycle until a new request is accepted.
REQ-017 SHALL remain in SETUP exactly SETUP_CYC cycles, EN_HI exactly EN_HIGH_CYC cycles, and HOLD exactly HOLD_CYC cycles, using one down/up counter of at least 17 bits.
REQ-018 SHALL drive LCD_EN high only during EN_HI cycles, registered and glitch-free.
REQ-019 SHALL tie LCD_RW to 0 at all times.
REQ-020 SHALL go HOLD -> DONE, except as stated under Configuration.
REQ-021 SHALL assert ctrl_Done for exactly one cycle in DONE, then return to IDLE.
REQ-022 SHALL ignore ctrl_Start edges while ctrl_Busy is high; ignored edges SHALL NOT be queued.
REQ-023 SHALL NOT start a second transfer if ctrl_Start is still high on return to IDLE; the edge detector SHALL track ctrl_Start in every state.
REQ-024 Nominal latency from acceptance edge to ctrl_Done SHALL be SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+1 cycles (34 with defaults).
REQ-025 SHALL treat a parameter value of 0 as 1 cycle.

Reset
REQ-026 SHALL, on asserted iRST_N and regardless of state (including mid-EN_HI), immediately force state IDLE, counter 0, LCD_EN 0, LCD_RS 0, LCD_RW 0, LCD_DATA 8'h00, ctrl_Done 0, ctrl_Busy 0, and previous ctrl_Start sample 0.
REQ-027 SHALL, after iRST_N deasserts while ctrl_Start is held high, accept that as a rising edge on the first clock.

Configuration
REQ-028 SHALL honour macro LCD_LONG_WAIT_EN.
- Defined: after HOLD, when the latched RS is 0 and latched DATA is 8'h01 or 8'h02, the block SHALL enter LONG_WAIT for LONG_WAIT_CYC cycles before DONE, with ctrl_Busy held high; all other transfers go HOLD -> DONE.
- Undefined: the LONG_WAIT state and logic SHALL be absent, and every transfer SHALL go HOLD -> DONE.

Verification
REQ-029 Reset, then ctrl_RS=0, ctrl_DATA=8'h38 with a ctrl_Start pulse -> LCD_DATA=8'h38, LCD_RS=0, LCD_EN high for exactly 25 cycles starting 5 cycles after the edge, ctrl_Done a single pulse 34 cycles after the edge.
REQ-030 ctrl_Start held high for 100 cycles with ctrl_RS=1, ctrl_DATA=8'h41 -> exactly one LCD_EN pulse and one ctrl_Done pulse.
REQ-031 A second ctrl_Start edge 10 cycles after the first, with DATA=8'h55 -> ignored; LCD_DATA stays 8'h41 and exactly one ctrl_Done pulse occurs.
REQ-032 iRST_N asserted during EN_HI -> LCD_EN=0 and all outputs at reset values in the same cycle; no ctrl_Done.
REQ-033 With LCD_LONG_WAIT_EN defined, command 8'h01 -> ctrl_Done 82034 cycles after the edge; command 8'h0C -> 34 cycles; data 8'h01 with RS=1 -> 34 cycles.
REQ-034 Back-to-back transfers, the upstream sequencer re-raising ctrl_Start 1 cycle after ctrl_Done, 8'h38/8'h0C/8'h01/8'h06 -> four correct LCD_EN pulses in order, no dropped request.
